acc_processor_param: RTL and testbench

//  Parametrised successor to the 8-bit accumulator processor: single accumulator A, carry C, PC, IR, unified sync-read RAM.

---
 rtl/acc_processor_param.sv | 221 ++++++++++++++++++++++
 tb/tb_acc_processor_param.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_processor_param.sv
// -----------------------------------------------------------------------------
// acc_processor_param
// Parametrised single-accumulator processor: accumulator A, carry C, PC, IR
// and one unified synchronous-read RAM shared by code and data. A program is
// written into RAM through the loader port while init=1; dropping init starts
// execution at address 0. Console I/O uses ready/valid handshakes.
//
// Instruction word: {opcode[DATA_W-1:DATA_W-4], ..., addr[ADDR_W-1:0]};
// the bits between opcode and addr are ignored. Requires DATA_W >= ADDR_W+4.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   init                program-load mode; core held and cleared
//   prog_we/addr/data   loader write port (accepted only while init=1)
//   in, in_valid        input operand for IN; in_ready high while IN waits
//   out, out_valid      output register written by OUT; out_ready accepts
//   halt                set by HALT, cleared by reset or init
//   dbg_pc/ir/acc       debug taps of PC, IR and A
// -----------------------------------------------------------------------------
module acc_processor_param #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halt,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [DATA_W-1:0] dbg_ir,
  output logic [DATA_W-1:0] dbg_acc
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_IN_WAIT, S_OUT_WAIT, S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_IN, OP_OUT,
    OP_JMP, OP_JZ, OP_JP, OP_JC, OP_INC, OP_DEC, OP_NOP, OP_HALT
  } op_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir, acc;
  logic              c;

  // RAM and its port controls
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [DATA_W-1:0] wdata;
  logic              ram_we;
  logic              out_wr;

  op_t               ir_op;
  logic [ADDR_W-1:0] ir_addr;

  assign ir_op   = op_t'(ir[DATA_W-1 -: 4]);
  assign ir_addr = ir[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // State register. Reset lands in FETCH; if init is already high the first
  // edge moves to LOAD, and loader writes are accepted in any state while init
  // is high, so a loader holding init through reset loses nothing. This keeps
  // the async reset value a constant.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // Next state, RAM addressing and handshake strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    raddr    = pc;
    ram_we   = 1'b0;
    waddr    = prog_addr;
    wdata    = prog_data;
    in_ready = 1'b0;
    out_wr   = 1'b0;
    if (init) begin
      // init aborts whatever is in flight; no STA write, no I/O transfer
      state_nx = S_LOAD;
      ram_we   = prog_we;
    end else begin
      case (state)
        S_LOAD:   state_nx = S_FETCH;
        S_FETCH:  state_nx = S_DECODE;
        S_DECODE: begin
          // operand read is issued from the word arriving now, one cycle
          // before it lands in IR
          raddr    = q[ADDR_W-1:0];
          state_nx = S_EXEC;
        end
        S_EXEC: begin
          state_nx = S_FETCH;
          case (ir_op)
            OP_STA: begin
              ram_we = 1'b1;
              waddr  = ir_addr;
              wdata  = acc;
            end
            OP_IN: begin
              in_ready = 1'b1;
              if (!in_valid) state_nx = S_IN_WAIT;
            end
            OP_OUT: begin
              if (!out_valid || out_ready) out_wr   = 1'b1;
              else                         state_nx = S_OUT_WAIT;
            end
            OP_HALT: state_nx = S_HALTED;
            default: ;
          endcase
        end
        S_IN_WAIT: begin
          in_ready = 1'b1;
          if (in_valid) state_nx = S_FETCH;
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            out_wr   = 1'b1;
            state_nx = S_FETCH;
          end
        end
        S_HALTED: ;
        default:  state_nx = S_FETCH;
      endcase
    end
    // a reset arriving on the write edge must not commit a store
    if (reset) ram_we = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      acc       <= '0;
      c         <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      halt      <= 1'b0;
    end else if (init || state == S_LOAD) begin
      pc        <= '0;
      acc       <= '0;
      c         <= 1'b0;
      out_valid <= 1'b0;
      halt      <= 1'b0;
    end else begin
      // output register: a same-cycle accept and write leaves valid high
      if (out_wr) begin
        out       <= acc;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (in_ready && in_valid) acc <= in;

      case (state)
        S_DECODE: begin
          ir <= q;
          pc <= pc + ADDR_W'(1);
        end
        S_EXEC: begin
          case (ir_op)
            OP_LDA: acc <= q;
            OP_ADD: {c, acc} <= {1'b0, acc} + {1'b0, q};
            OP_SUB: begin
              acc <= acc - q;
              c   <= (acc >= q);
            end
            OP_AND: acc <= acc & q;
            OP_OR:  acc <= acc | q;
            OP_JMP: pc <= ir_addr;
            OP_JZ:  if (acc == '0) pc <= ir_addr;
            OP_JP:  if (acc != '0 && !acc[DATA_W-1]) pc <= ir_addr;
            OP_JC:  if (c) pc <= ir_addr;
            OP_INC: {c, acc} <= {1'b0, acc} + (DATA_W+1)'(1);
            OP_DEC: begin
              acc <= acc - DATA_W'(1);
              c   <= (acc != '0);
            end
            OP_HALT: halt <= 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Unified RAM, synchronous read, not cleared by reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end

  assign dbg_pc  = pc;
  assign dbg_ir  = ir;
  assign dbg_acc = acc;

endmodule

// File: tb/tb_acc_processor_param.sv
// -----------------------------------------------------------------------------
// tb_acc_processor_param
// Self-checking bench for acc_processor_param (DATA_W=12, ADDR_W=8).
// An instruction-level reference model advances once per clock edge, with
// instruction timing expressed as a cycle count inside the current
// instruction. Directed programs pin literal results; random programs with
// random handshakes, inits and resets are compared every cycle.
// -----------------------------------------------------------------------------
module tb_acc_processor_param;
  localparam int DW    = 12;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int MASK  = 'hFFF;

  logic          clk = 1'b0;
  logic          reset, init, prog_we, in_valid, out_ready;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data, in_d;
  logic          in_ready, out_valid, halt;
  logic [DW-1:0] out_d, dbg_ir, dbg_acc;
  logic [AW-1:0] dbg_pc;

  acc_processor_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .in        (in_d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halt      (halt),
    .dbg_pc    (dbg_pc),
    .dbg_ir    (dbg_ir),
    .dbg_acc   (dbg_acc)
  );

  always #5 clk = ~clk;

  int checks, failures;

  // reference model state
  int mmem [DEPTH];
  int mpc, macc, mout, minstr, cyc;   // cyc: 0 fetch,1 decode,2 exec,3 I/O stall
  bit mc, mvalid, mhalt, mload;

  function automatic int ins(int o, int a);
    return (o << 8) | a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mpc = 0; macc = 0; mc = 0; mvalid = 0; mhalt = 0; cyc = 0;
  endtask

  task automatic model_reset();
    model_clear();
    mout = 0; minstr = 0; mload = 0;
  endtask

  task automatic m_exec(output bit outwr);
    int opc, a, m, t;
    opc = (minstr >> 8) & 15;
    a   = minstr & 255;
    m   = mmem[a];
    outwr = 0;
    cyc   = 0;
    case (opc)
      0:  macc = m;
      1:  mmem[a] = macc;
      2:  begin t = macc + m; macc = t & MASK; mc = (t > MASK); end
      3:  begin mc = (macc >= m); macc = (macc - m) & MASK; end
      4:  macc = macc & m;
      5:  macc = macc | m;
      6:  if (in_valid) macc = int'(in_d); else cyc = 3;
      7:  if (!mvalid || out_ready) outwr = 1; else cyc = 3;
      8:  mpc = a;
      9:  if (macc == 0) mpc = a;
      10: if (macc != 0 && macc < 2048) mpc = a;
      11: if (mc) mpc = a;
      12: begin t = macc + 1; macc = t & MASK; mc = (t > MASK); end
      13: begin mc = (macc != 0); macc = (macc - 1) & MASK; end
      15: mhalt = 1;
      default: ;
    endcase
  endtask

  // advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    bit outwr;
    outwr = 0;
    if (reset) begin
      model_reset();
    end else if (init) begin
      if (prog_we) mmem[prog_addr] = int'(prog_data);
      model_clear();
      mload = 1;
    end else if (mload) begin
      model_clear();
      mload = 0;
    end else begin
      if (!mhalt) begin
        if (cyc == 0) cyc = 1;
        else if (cyc == 1) begin
          minstr = mmem[mpc];
          mpc = (mpc + 1) % DEPTH;
          cyc = 2;
        end else m_exec(outwr);
      end
      if (outwr) begin mout = macc; mvalid = 1; end
      else if (out_ready) mvalid = 0;
    end
  endtask

  task automatic compare_all();
    bit exp_rdy;
    exp_rdy = !reset && !init && !mload && !mhalt && cyc >= 2 && ((minstr >> 8) & 15) == 6;
    chk("pc", dbg_pc, mpc);
    chk("acc", dbg_acc, macc);
    chk("ir", dbg_ir, minstr);
    chk("out", out_d, mout);
    chk("out_valid", out_valid, mvalid);
    chk("halt", halt, mhalt);
    chk("in_ready", in_ready, exp_rdy);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic load_word(input int a, input int d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = DW'(d);
    step();
    prog_we = 1'b0;
  endtask

  task automatic load_pairs(input int p[$]);
    init = 1'b1; prog_we = 1'b0;
    step();
    for (int i = 0; i + 1 < p.size(); i += 2) load_word(p[i], p[i+1]);
  endtask

  task automatic start_run();
    init = 1'b0; prog_we = 1'b0;
    step();
  endtask

  task automatic run_until_halt(input int budget, input string name);
    int n;
    n = 0;
    while (halt !== 1'b1 && n < budget) begin step(); n++; end
    chk({name, "_halt_reached"}, halt, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    reset = 1'b0;
  endtask

  function automatic int rand_word();
    int w;
    w = int'($urandom & 32'hFFF);
    if ((w >> 8) == 15 && ($urandom % 4) != 0) w = (w & 'hFF) | 'hE00;
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p[$];
    checks = 0; failures = 0;
    reset = 1'b1; init = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    in_d = '0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    compare_all();
    chk("rst_pc", dbg_pc, 0);
    chk("rst_out_valid", out_valid, 0);
    step(); step();
    reset = 1'b0;

    // clear program memory to NOPs
    for (int a = 0; a < DEPTH; a++) load_word(a, 'hE00);

    // T1: LDA 10; ADD 11; OUT; HALT -> 0x7FF+0x801 wraps to 0
    out_ready = 1'b0;
    p = '{0, ins(0,10), 1, ins(2,11), 2, ins(7,0), 3, ins(15,0), 10, 'h7FF, 11, 'h801};
    load_pairs(p);
    start_run();
    repeat (11) step();
    chk("t1_halt_early", halt, 0);
    step();
    chk("t1_halt", halt, 1);
    chk("t1_out", out_d, 0);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_acc", dbg_acc, 0);

    // T2: SUB borrow, JC not taken; ADD carry, JC taken
    p = '{0, ins(0,30), 1, ins(3,31), 2, ins(11,20), 3, ins(0,32), 4, ins(2,32),
          5, ins(11,9), 6, ins(15,0), 9, ins(15,0), 20, ins(15,0),
          30, 3, 31, 5, 32, 'h800};
    load_pairs(p);
    start_run();
    repeat (6) step();
    chk("t2_sub_acc", dbg_acc, 'hFFE);
    repeat (3) step();
    chk("t2_jc_not_taken_pc", dbg_pc, 3);
    repeat (6) step();
    chk("t2_add_acc", dbg_acc, 0);
    repeat (3) step();
    chk("t2_jc_taken_pc", dbg_pc, 9);
    repeat (3) step();
    chk("t2_halt", halt, 1);
    chk("t2_final_pc", dbg_pc, 10);

    // T3: IN stalls with in_valid low, then takes 0x123
    in_valid = 1'b0; out_ready = 1'b1;
    p = '{0, ins(6,0), 1, ins(7,0), 2, ins(15,0)};
    load_pairs(p);
    start_run();
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_in_ready_wait", in_ready, 1);
      chk("t3_pc_frozen", dbg_pc, 1);
      step();
    end
    in_d = 12'h123; in_valid = 1'b1;
    chk("t3_in_ready_pre", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t3_acc", dbg_acc, 'h123);
    chk("t3_in_ready_after", in_ready, 0);
    run_until_halt(30, "t3");
    chk("t3_out", out_d, 'h123);

    // T4: second OUT stalls while consumer is not ready
    out_ready = 1'b0;
    p = '{0, ins(0,40), 1, ins(7,0), 2, ins(0,41), 3, ins(7,0), 4, ins(15,0),
          40, 'hAAA, 41, 'h555};
    load_pairs(p);
    start_run();
    repeat (15) step();
    chk("t4_out_held", out_d, 'hAAA);
    chk("t4_out_valid_held", out_valid, 1);
    chk("t4_pc_stalled", dbg_pc, 4);
    out_ready = 1'b1;
    step();
    chk("t4_out_second", out_d, 'h555);
    chk("t4_out_valid_kept", out_valid, 1);
    step();
    chk("t4_out_valid_clr", out_valid, 0);
    run_until_halt(30, "t4");

    // T5: DEC/JZ/JMP loop at the top of memory, PC wraps past 255
    p = '{0, ins(0,50), 1, ins(8,253), 253, ins(13,0), 254, ins(9,10),
          255, ins(8,253), 10, ins(15,0), 50, 3};
    load_pairs(p);
    start_run();
    repeat (14) step();
    chk("t5_pc_wrap", dbg_pc, 0);
    chk("t5_ir_jmp", dbg_ir, ins(8,253));
    run_until_halt(100, "t5");
    chk("t5_acc", dbg_acc, 0);
    chk("t5_pc", dbg_pc, 11);

    // T6: reset during STA execute, init during decode; RAM[61] untouched
    p = '{0, ins(0,60), 1, ins(1,61), 2, ins(15,0), 60, 'h321, 61, 'h0AB};
    load_pairs(p);
    start_run();
    repeat (5) step();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("t6_rst_pc", dbg_pc, 0);
    chk("t6_rst_acc", dbg_acc, 0);
    chk("t6_rst_ir", dbg_ir, 0);
    chk("t6_rst_halt", halt, 0);
    step(); step();
    reset = 1'b0;
    repeat (4) step();
    init = 1'b1;
    step(); step();
    chk("t6_init_pc", dbg_pc, 0);
    chk("t6_init_acc", dbg_acc, 0);
    load_word(0, ins(0,61));
    load_word(1, ins(7,0));
    load_word(2, ins(15,0));
    start_run();
    run_until_halt(40, "t6");
    chk("t6_ram_unchanged", out_d, 'h0AB);

    // random programs, handshakes and occasional resets
    for (int r = 0; r < 10; r++) begin
      init = 1'b1; prog_we = 1'b0;
      step();
      for (int a = 0; a < DEPTH; a++) load_word(a, rand_word());
      start_run();
      for (int c = 0; c < 250; c++) begin
        in_valid  = ($urandom % 3) == 0;
        in_d      = DW'($urandom);
        out_ready = ($urandom % 2) == 0;
        if (($urandom % 300) == 0) pulse_reset();
        else step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
